// File: rtl/aes_pkg.sv
// Shared AES byte-level constants and GF(2^8) helpers used by the S-box
// datapath: field multiply plus the forward and inverse affine transforms.
package aes_pkg;

  typedef logic [7:0] byte_t;

  localparam byte_t AES_POLY      = 8'h1B;
  localparam byte_t SBOX_AFFINE_C = 8'h63;
  localparam byte_t INV_AFFINE_C  = 8'h05;

  // Shift-and-add multiply; reduction folds x^8 back in as AES_POLY.
  function automatic byte_t gf_mul(input byte_t a, input byte_t b);
    byte_t p;
    byte_t x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ AES_POLY) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic byte_t gf_sq(input byte_t a);
    return gf_mul(a, a);
  endfunction

  // Bit i of {b[k-1:0], b[7:k]} is b[(i+k)%8], so each term is one rotation.
  function automatic byte_t affine(input byte_t b);
    return b
         ^ {b[3:0], b[7:4]}
         ^ {b[4:0], b[7:5]}
         ^ {b[5:0], b[7:6]}
         ^ {b[6:0], b[7]}
         ^ SBOX_AFFINE_C;
  endfunction

  function automatic byte_t inv_affine(input byte_t b);
    return {b[1:0], b[7:2]}
         ^ {b[4:0], b[7:5]}
         ^ {b[6:0], b[7]}
         ^ INV_AFFINE_C;
  endfunction

endpackage

// File: rtl/aes_sbox_if.sv
// Byte-stream port bundle for one S-box lane: qualified input byte in,
// qualified substituted byte out.
interface aes_sbox_if;
  import aes_pkg::*;

  logic  in_valid;
  byte_t in;
  logic  out_valid;
  byte_t out;

  modport master (output in_valid, output in, input out_valid, input out);
  modport slave  (input in_valid, input in, output out_valid, output out);

endinterface

// File: rtl/aes_sbox_gf256_inv.sv
// Combinational multiplicative inverse in GF(2^8) mod 0x11B, computed as
// a^254; zero maps to zero without a special case.
module gf256_inv
  import aes_pkg::*;
(
  input  byte_t a,
  output byte_t y
);

  byte_t a2, a4, a8, a16, a32, a64, a128;
  byte_t p0, p1, p2, p3, p4;

  // Repeated squaring gives a^(2^k); multiplying k=1..7 sums exponents to 254.
  assign a2   = gf_sq(a);
  assign a4   = gf_sq(a2);
  assign a8   = gf_sq(a4);
  assign a16  = gf_sq(a8);
  assign a32  = gf_sq(a16);
  assign a64  = gf_sq(a32);
  assign a128 = gf_sq(a64);

  assign p0 = gf_mul(a2, a4);
  assign p1 = gf_mul(a8, a16);
  assign p2 = gf_mul(a32, a64);
  assign p3 = gf_mul(p0, p1);
  assign p4 = gf_mul(p2, a128);
  assign y  = gf_mul(p3, p4);

endmodule

// File: rtl/aes_sbox.sv
// Registered AES S-box lane: forward (Affine after Inv) or inverse
// (Inv after InvAffine) substitution with one-cycle latency.
module aes_sbox
  import aes_pkg::*;
#(
  parameter bit INVERSE = 1'b0
) (
  input logic        clk,
  input logic        rst_n,
  aes_sbox_if.slave  bus
);

  byte_t inv_in;
  byte_t inv_out;
  byte_t sub_byte;

  gf256_inv u_inv (
    .a (inv_in),
    .y (inv_out)
  );

  // The affine step sits before the inverse for decryption, after it for encryption.
  generate
    if (INVERSE) begin : g_inverse
      assign inv_in   = inv_affine(bus.in);
      assign sub_byte = inv_out;
    end else begin : g_forward
      assign inv_in   = bus.in;
      assign sub_byte = affine(inv_out);
    end
  endgenerate

  // out only loads on a qualified byte, so idle cycles hold the last result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.out       <= 8'h00;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) bus.out <= sub_byte;
    end
  end

endmodule

// File: tb/tb_aes_sbox.sv
// Directed bench for forward, inverse and cascaded (forward->inverse) S-box
// lanes against the published FIPS-197 table.
module tb_aes_sbox;
  import aes_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   passCount = 0;
  int   checkCount = 0;

  aes_sbox_if fwdIf ();
  aes_sbox_if invIf ();
  aes_sbox_if cascIf ();

  aes_sbox #(.INVERSE(1'b0)) u_fwd  (.clk(clk), .rst_n(rst_n), .bus(fwdIf.slave));
  aes_sbox #(.INVERSE(1'b1)) u_inv  (.clk(clk), .rst_n(rst_n), .bus(invIf.slave));
  aes_sbox #(.INVERSE(1'b1)) u_casc (.clk(clk), .rst_n(rst_n), .bus(cascIf.slave));

  assign cascIf.in_valid = fwdIf.out_valid;
  assign cascIf.in       = fwdIf.out;

  always #5 clk = ~clk;

  logic [7:0] fwdRef [0:255] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };
  logic [7:0] invRef [0:255];

  // Drive both lanes, then step past the next rising edge to a safe sample point.
  task automatic applyStimulus(input logic rstVal, input logic validVal,
                               input logic [7:0] fwdIn, input logic [7:0] invIn);
    rst_n          = rstVal;
    fwdIf.in_valid = validVal;
    fwdIf.in       = fwdIn;
    invIf.in_valid = validVal;
    invIf.in       = invIn;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
  endtask

  task automatic checkLanes(input string tag, input logic [7:0] fwdExp, input logic fwdVld,
                            input logic [7:0] invExp, input logic invVld);
    checkOutput({tag, " fwd out"},   fwdIf.out, fwdExp);
    checkOutput({tag, " fwd valid"}, 8'(fwdIf.out_valid), 8'(fwdVld));
    checkOutput({tag, " inv out"},   invIf.out, invExp);
    checkOutput({tag, " inv valid"}, 8'(invIf.out_valid), 8'(invVld));
  endtask

  logic [7:0] spotIn  [0:4] = '{8'h00, 8'h01, 8'h53, 8'h8f, 8'hff};
  logic [7:0] spotOut [0:4] = '{8'h63, 8'h7c, 8'hed, 8'h73, 8'h16};

  initial begin
    for (int i = 0; i < 256; i++) invRef[fwdRef[i]] = 8'(i);

    $display("[TB] reset with valid input held high");
    applyStimulus(1'b0, 1'b1, 8'h8f, 8'h73);
    checkLanes("reset1", 8'h00, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h8f, 8'h73);
    checkLanes("reset2", 8'h00, 1'b0, 8'h00, 1'b0);
    checkOutput("reset casc out", cascIf.out, 8'h00);
    checkOutput("reset casc valid", 8'(cascIf.out_valid), 8'h00);
    applyStimulus(1'b1, 1'b1, 8'h8f, 8'h73);
    checkLanes("release", 8'h73, 1'b1, 8'h8f, 1'b1);

    $display("[TB] spot values");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b1, spotIn[i], spotOut[i]);
      checkLanes($sformatf("spot %h", spotIn[i]), spotOut[i], 1'b1, spotIn[i], 1'b1);
    end

    $display("[TB] hold while idle");
    applyStimulus(1'b1, 1'b1, 8'h8f, 8'h73);
    checkLanes("hold load", 8'h73, 1'b1, 8'h8f, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 8'h00, 8'hxx);
      checkLanes($sformatf("idle %0d", i), 8'h73, 1'b0, 8'h8f, 1'b0);
    end

    $display("[TB] reset mid-stream");
    applyStimulus(1'b1, 1'b1, 8'h8f, 8'h73);
    applyStimulus(1'b0, 1'b1, 8'h01, 8'h7c);
    checkLanes("midreset", 8'h00, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'h53, 8'hed);
    checkLanes("after midreset", 8'hed, 1'b1, 8'h53, 1'b1);

    $display("[TB] exhaustive stream with cascade round trip");
    for (int i = 0; i < 256; i++) begin
      applyStimulus(1'b1, 1'b1, 8'(i), 8'(i));
      checkLanes($sformatf("stream %h", i[7:0]), fwdRef[i], 1'b1, invRef[i], 1'b1);
      if (i > 0) begin
        checkOutput($sformatf("casc %h out", i[7:0] - 8'd1), cascIf.out, 8'(i - 1));
        checkOutput("casc valid", 8'(cascIf.out_valid), 8'h01);
      end
    end
    applyStimulus(1'b1, 1'b0, 8'h00, 8'h00);
    checkLanes("stream drain", 8'h16, 1'b0, 8'h7d, 1'b0);
    checkOutput("casc ff out", cascIf.out, 8'hff);
    checkOutput("casc ff valid", 8'(cascIf.out_valid), 8'h01);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/aes_sbox.md
Name: aes_sbox

Overview:
- AES-128 SubBytes byte substitution element, registered.
- Maps one input byte to its AES S-box value per FIPS-197; optionally the inverse S-box via a parameter.
- Instanced 16x inside the SubBytes stage of the round datapath.
- Single clock domain; one byte per cycle throughput, 1-cycle latency.

Parameters:
- INVERSE, 0, 0 = forward S-box (encryption); 1 = inverse S-box (decryption).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- in_valid  input  1  input byte qualifier.
- in  input  8  byte to substitute.
- out_valid  output  1  out holds a freshly computed result this cycle.
- out  output  8  substituted byte, registered.

Behaviour:
- Reset: while rst_n=0 at a rising edge, out<=8'h00 and out_valid<=0. Reset has priority over in_valid.
- Forward mapping (INVERSE=0): out = Affine(Inv(in)).
  - Inv is the multiplicative inverse in GF(2^8) modulo x^8+x^4+x^3+x+1 (0x11B), with Inv(0)=0.
  - Affine: b'_i = b_i ^ b_(i+4)%8 ^ b_(i+5)%8 ^ b_(i+6)%8 ^ b_(i+7)%8 ^ c_i, where c=8'h63.
- Inverse mapping (INVERSE=1): out = Inv(InvAffine(in)).
  - InvAffine: b'_i = b_(i+2)%8 ^ b_(i+5)%8 ^ b_(i+7)%8 ^ d_i, where d=8'h05.
- Result must equal the FIPS-197 tables for all 256 inputs.
- Implementation freedom: a 256-entry case LUT or a GF-inverse-plus-affine datapath. Both are acceptable; the output must be bit-exact.
- Latency: in sampled at rising edge N with in_valid=1 -> out valid and out_valid=1 after edge N.
- in_valid=0 at an edge: out holds its previous value; out_valid<=0.
- Back-to-back valid inputs: one result per cycle, no bubbles, no backpressure.
- X/undriven in while in_valid=0 must not affect out.
- Reset asserted mid-stream: the in-flight result is discarded; out=00, out_valid=0 after that edge.

Decomposition:
- Package aes_pkg:
  - AES_POLY=8'h1B (reduction byte).
  - SBOX_AFFINE_C=8'h63.
  - INV_AFFINE_C=8'h05.
  - Byte typedef.
  - Functions gf_mul and affine/inv_affine.
- Natural sub-module: gf256_inv, a combinational multiplicative inverse with 0->0. It is shared by the forward and inverse variants.
- The top level handles only the affine step and the output register.

Test Plan:
- Reset: rst_n=0 for 2 cycles with in_valid=1, in=8'h8f -> out=00, out_valid=0. Release, then one cycle later -> out=73, out_valid=1.
- Forward spot values (INVERSE=0): 00->63, 01->7c, 53->ed, 8f->73, ff->16, each one cycle after its valid input.
- Inverse spot values (INVERSE=1): 63->00, 7c->01, ed->53, 73->8f, 16->ff.
- Exhaustive streaming: in_valid=1 for 256 consecutive cycles, in=00..ff, checked against a reference table.
  - Requires out_valid=1 every cycle after the first, with no gaps.
  - Cascading a forward instance into an inverse instance must return the original byte for all 256 values.
- Hold/idle: apply 8f with valid, then in_valid=0 with in=00 for 3 cycles -> out stays 73; out_valid drops to 0 after the first idle edge.
- Reset mid-stream: valid in=01 at edge N with rst_n=0 at the same edge -> out=00, out_valid=0. Next valid input 53 -> ed.
